// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: one tagged op in flight, ALU
// operands held from registers, tagged response with backpressure, timeout and reserved-op errors.

package opcode_pkg;
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_MUL  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_SP4  = 4'h9,
        OP_RES1 = 4'hE,
        OP_RES2 = 4'hF
    } opcode_t;
endpackage

module alu_issue_ctrl
    import opcode_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy,
    output logic [15:0]      ops_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t             state_reg, state_next;
    opcode_t            op_reg, op_next;
    logic [31:0]        a_reg, a_next;
    logic [31:0]        b_reg, b_next;
    logic [TAG_W-1:0]   tag_reg, tag_next;
    logic [31:0]        result_reg, result_next;
    logic               err_reg, err_next;
    logic [7:0]         tmo_reg, tmo_next;
    logic [15:0]        ops_reg, ops_next;
    logic [7:0]         tmo_inc;

    assign tmo_inc = tmo_reg + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            op_reg     <= OP_NOP;
            a_reg      <= '0;
            b_reg      <= '0;
            tag_reg    <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            tmo_reg    <= '0;
            ops_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            tag_reg    <= tag_next;
            result_reg <= result_next;
            err_reg    <= err_next;
            tmo_reg    <= tmo_next;
            ops_reg    <= ops_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        tag_next    = tag_reg;
        result_next = result_reg;
        err_next    = err_reg;
        tmo_next    = tmo_reg;
        ops_next    = ops_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    op_next  = opcode_t'(req_op);
                    a_next   = req_a;
                    b_next   = req_b;
                    tag_next = req_tag;
                    // Reserved opcodes are answered directly; the ALU never sees them.
                    if (req_op == OP_RES1 || req_op == OP_RES2) begin
                        state_next  = S_RESP;
                        err_next    = 1'b1;
                        result_next = '0;
                    end else begin
                        state_next = S_EXEC;
                        tmo_next   = '0;
                    end
                end
            end
            S_EXEC: begin
                if (alu_done) begin
                    state_next  = S_RESP;
                    result_next = alu_result;
                    err_next    = 1'b0;
                end else begin
                    tmo_next = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        state_next  = S_RESP;
                        result_next = '0;
                        err_next    = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                    if (!err_reg) begin
                        ops_next = ops_reg + 16'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ALU inputs are only non-zero while an operation is executing.
    assign alu_op     = (state_reg == S_EXEC) ? op_reg : OP_NOP;
    assign alu_a      = (state_reg == S_EXEC) ? a_reg : 32'd0;
    assign alu_b      = (state_reg == S_EXEC) ? b_reg : 32'd0;

    assign req_ready  = (state_reg == S_IDLE) && !rst;
    assign rsp_valid  = (state_reg == S_RESP);
    assign rsp_result = result_reg;
    assign rsp_tag    = tag_reg;
    assign rsp_err    = err_reg;
    assign busy       = (state_reg != S_IDLE);
    assign ops_count  = ops_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU that can be
// made to hang (alu_done held low) to exercise the timeout path.

module tb_alu_issue_ctrl;

    localparam int TAG_W = 5;
    localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, MUL = 4'h3,
                           SP4 = 4'h9, RES1 = 4'hE;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic [3:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;
    logic             alu_done;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;
    logic [15:0]      ops_count;
    logic             alu_hang;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_done   (alu_done),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .ops_count  (ops_count)
    );

    // Behavioural ALU; SP4 is modelled as a*3.
    always_comb begin
        case (alu_op)
            ADD:     alu_result = alu_a + alu_b;
            SUB:     alu_result = alu_a - alu_b;
            MUL:     alu_result = alu_a * alu_b;
            SP4:     alu_result = alu_a * 32'd3;
            default: alu_result = 32'd0;
        endcase
        alu_done = !alu_hang && (alu_op != NOP);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_seen", 32'(rsp_valid), 1);
        $display("[TB] rsp tag=%0d result=0x%08h err=%0d latency=%0d", rsp_tag, rsp_result, rsp_err, lat);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int nrsp;
        int exec_cycles;
        int seen;
        int idx;
        bit acc;
        logic [31:0] rres [4];
        int rcyc [4];
        logic [3:0]  b2b_op [2];
        logic [31:0] b2b_a  [2];
        logic [31:0] b2b_b  [2];

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = NOP;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        alu_hang  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ops", 32'(ops_count), 0);
        chk("rst_alu_op", 32'(alu_op), 32'(NOP));
        chk("rst_result", rsp_result, 0);
        chk("rst_tag", 32'(rsp_tag), 0);
        chk("rst_err", 32'(rsp_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // ADD 5+7
        issue(ADD, 32'd5, 32'd7, 5'd3);
        chk("add_exec_busy", 32'(busy), 1);
        chk("add_exec_alu_op", 32'(alu_op), 32'(ADD));
        wait_rsp(lat);
        chk("add_lat", lat, 1);
        chk("add_result", rsp_result, 12);
        chk("add_tag", 32'(rsp_tag), 3);
        chk("add_err", 32'(rsp_err), 0);
        handshake();
        chk("add_ops", 32'(ops_count), 1);
        chk("add_ready_after", 32'(req_ready), 1);

        // SUB 3-5 held under backpressure
        rsp_ready = 1'b0;
        issue(SUB, 32'd3, 32'd5, 5'd4);
        wait_rsp(lat);
        repeat (4) begin
            chk("sub_hold_result", rsp_result, 32'hFFFF_FFFE);
            chk("sub_hold_valid", 32'(rsp_valid), 1);
            chk("sub_hold_ready", 32'(req_ready), 0);
            chk("sub_hold_busy", 32'(busy), 1);
            @(negedge clk);
        end
        chk("sub_tag", 32'(rsp_tag), 4);
        handshake();
        chk("sub_released", 32'(rsp_valid), 0);
        chk("sub_ops", 32'(ops_count), 2);

        // Back-to-back MUL then SP4 with req_valid held high
        b2b_op[0] = MUL; b2b_a[0] = 32'h0001_0000; b2b_b[0] = 32'h0001_0000;
        b2b_op[1] = SP4; b2b_a[1] = 32'd7;         b2b_b[1] = 32'd0;
        idx = 0;
        nrsp = 0;
        req_valid = 1'b1;
        req_op = b2b_op[0]; req_a = b2b_a[0]; req_b = b2b_b[0]; req_tag = 5'd10;
        for (int cyc = 0; cyc < 12; cyc++) begin
            acc = req_ready && req_valid;
            if (rsp_valid && nrsp < 4) begin
                rres[nrsp] = rsp_result;
                rcyc[nrsp] = cyc;
                nrsp++;
                chk("b2b_alu_nop", 32'(alu_op), 32'(NOP));
                $display("[TB] rsp tag=%0d result=0x%08h err=%0d cycle=%0d", rsp_tag, rsp_result, rsp_err, cyc);
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 2) begin
                    req_op = b2b_op[idx]; req_a = b2b_a[idx]; req_b = b2b_b[idx]; req_tag = 5'd11;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_count", nrsp, 2);
        if (nrsp == 2) begin
            chk("b2b_mul", rres[0], 32'h0000_0000);
            chk("b2b_sp4", rres[1], 32'd21);
            chk("b2b_gap", rcyc[1] - rcyc[0], 3);
        end
        chk("b2b_ops", 32'(ops_count), 4);

        // Reserved opcode
        issue(RES1, 32'd1, 32'd2, 5'd9);
        chk("res_alu_nop", 32'(alu_op), 32'(NOP));
        wait_rsp(lat);
        chk("res_lat", lat, 0);
        chk("res_err", 32'(rsp_err), 1);
        chk("res_result", rsp_result, 0);
        chk("res_tag", 32'(rsp_tag), 9);
        handshake();
        chk("res_ops", 32'(ops_count), 4);

        // Timeout with the ALU hung
        alu_hang = 1'b1;
        issue(ADD, 32'd8, 32'd9, 5'd12);
        exec_cycles = 0;
        while (!rsp_valid && exec_cycles < 40) begin
            if (alu_op != ADD || alu_a != 32'd8 || alu_b != 32'd9)
                chk("tmo_alu_stable", {alu_op, alu_a[27:0]}, {ADD, 28'd8});
            @(negedge clk);
            exec_cycles++;
        end
        $display("[TB] rsp tag=%0d result=0x%08h err=%0d exec_cycles=%0d", rsp_tag, rsp_result, rsp_err, exec_cycles);
        chk("tmo_cycles", exec_cycles, 15);
        chk("tmo_err", 32'(rsp_err), 1);
        chk("tmo_result", rsp_result, 0);
        handshake();
        chk("tmo_ops", 32'(ops_count), 4);
        alu_hang = 1'b0;
        issue(ADD, 32'd1, 32'd2, 5'd13);
        wait_rsp(lat);
        chk("post_tmo_result", rsp_result, 3);
        chk("post_tmo_err", 32'(rsp_err), 0);
        handshake();
        chk("post_tmo_ops", 32'(ops_count), 5);

        // Reset during EXEC
        alu_hang = 1'b1;
        issue(ADD, 32'd2, 32'd2, 5'd14);
        chk("rst_exec_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hi_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
        #1;
        chk("rst_exec_valid", 32'(rsp_valid), 0);
        chk("rst_exec_busy0", 32'(busy), 0);
        chk("rst_exec_ops", 32'(ops_count), 0);
        chk("rst_exec_alu_op", 32'(alu_op), 32'(NOP));
        chk("rst_exec_ready", 32'(req_ready), 1);
        @(negedge clk);

        // Reset during RESP under backpressure
        alu_hang = 1'b0;
        rsp_ready = 1'b0;
        issue(SUB, 32'd10, 32'd4, 5'd7);
        wait_rsp(lat);
        chk("rst_resp_result", rsp_result, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_resp_valid", 32'(rsp_valid), 0);
        chk("rst_resp_busy", 32'(busy), 0);
        chk("rst_resp_ops", 32'(ops_count), 0);
        chk("rst_resp_alu_op", 32'(alu_op), 32'(NOP));
        rsp_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rst_no_rsp", seen, 0);
        chk("rst_final_ops", 32'(ops_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
